// File: rtl/inst_fetch_unit.sv
// Prefetch FIFO: small circular buffer with synchronous clear, no write-to-read bypass.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: none internally; the writer must use count to avoid overflow.
module fetch_fifo #(
   parameter int W     = 40,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          push_vld,
   input  logic [W-1:0]  push_dat,
   input  logic          pop_vld,
   output logic [W-1:0]  head_dat,
   output logic [CW-1:0] count
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  store [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // Entry storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push_vld && !clr && !rst) begin
         store[wr_ptr] <= push_dat;
      end
   end

   // Pointer and occupancy bookkeeping; clear wins over push/pop.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_vld) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop_vld) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push_vld, pop_vld})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_dat = store[rd_ptr];

endmodule

// Instruction fetch: keeps the PC, issues word reads, buffers returns for the decoder.
// Latency: request in cycle N, inst_valid in N+2; one instruction per cycle sustained.
// Backpressure: credit check on count+inflight stops issue when the buffer would fill.
module inst_fetch_unit #(
   parameter int                ADDR_W     = 8,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   output logic              imem_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [31:0]       inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              inst_valid,
   input  logic              inst_ready
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = 32 + ADDR_W;

   logic [ADDR_W-1:0] pc;
   logic              inflight;
   logic [ADDR_W-1:0] inflight_pc;
   logic              inflight_kill;

   logic [CW-1:0]     count;
   logic [EW-1:0]     head_dat;
   logic              pop;
   logic              push;
   logic [CW:0]       credit;

   // Head is valid whenever the buffer holds anything; no bypass from imem_data.
   assign inst_valid = (count != '0);
   assign pop        = inst_valid & inst_ready;

   // Entries held after this cycle if nothing new arrives: buffered + outstanding - leaving.
   // pop implies count >= 1, so this never underflows.
   assign credit  = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
   assign imem_en = run & ~rst & ~redirect & (credit < (CW+1)'(FIFO_DEPTH));

   assign imem_addr = pc;

   // A returning word is kept only if no redirect flushed it, now or when it was issued.
   assign push = inflight & ~inflight_kill & ~redirect;

   fetch_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .clr      (redirect),
      .push_vld (push),
      .push_dat ({imem_data, inflight_pc}),
      .pop_vld  (pop),
      .head_dat (head_dat),
      .count    (count)
   );

   // Empty stage presents an all-zero word, which decodes as a harmless NOP.
   assign inst    = inst_valid ? head_dat[EW-1:ADDR_W] : 32'h0000_0000;
   assign inst_pc = inst_valid ? head_dat[ADDR_W-1:0]  : '0;

   // PC and outstanding-request tracking; reset beats redirect beats issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc            <= RESET_PC;
         inflight      <= 1'b0;
         inflight_pc   <= '0;
         inflight_kill <= 1'b0;
      end else if (redirect) begin
         pc            <= redirect_pc;
         inflight      <= 1'b0;
         inflight_kill <= inflight;
      end else begin
         inflight <= imem_en;
         if (imem_en) begin
            inflight_pc   <= pc;
            pc            <= pc + ADDR_W'(1);
            inflight_kill <= 1'b0;
         end
      end
   end

endmodule
